// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fifo_pkg
//  Purpose   : Shared types and constants for the fifo buffer family.
//  Revision  : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Occupancy states of the two-entry registered buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing held, accepting
        BUSY  = 2'd1,   // one word in data_o, accepting
        FULL  = 2'd2    // data_o and skid both hold a word, not accepting
    } fifo_rbuf_state_e;

    // Number of storage entries in the registered buffer.
    localparam int C_FIFO_RBUF_DEPTH = 2;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_rbuf_if.sv
`default_nettype none
// ============================================================================
//  Interface : fifo_rbuf_if
//  Purpose   : Bundles the upstream and downstream valid/accept handshake of
//              a fifo_rbuf stage. The master side is the environment (source
//              and sink), the slave side is the buffer itself.
//  Revision  : 1.0  initial release
// ============================================================================
interface fifo_rbuf_if #(
    parameter int DATA_WIDTH = 32
) ();

    // Upstream: producer -> buffer
    logic [DATA_WIDTH-1:0] data_up;
    logic                  rdy_up;
    logic                  ack_up;

    // Downstream: buffer -> consumer
    logic [DATA_WIDTH-1:0] data_dn;
    logic                  rdy_dn;
    logic                  ack_dn;

    // Environment view: drives the producer side, consumes the output.
    modport master (
        output data_up, rdy_up, ack_dn,
        input  ack_up, data_dn, rdy_dn
    );

    // Buffer view.
    modport slave (
        input  data_up, rdy_up, ack_dn,
        output ack_up, data_dn, rdy_dn
    );

endinterface : fifo_rbuf_if
`default_nettype wire

// File: rtl/fifo_rbuf.sv
`default_nettype none
// ============================================================================
//  Module    : fifo_rbuf
//  Purpose   : Two-entry registered pipeline buffer. Every output (ack_o,
//              rdy_o, data_o) comes straight from a flop, so both the forward
//              data path and the backward accept path are cut. A skid register
//              absorbs the one word that may arrive while ack_o is still high
//              after the consumer stalls.
//  Revision  : 1.0  initial release
// ============================================================================
module fifo_rbuf
    import fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    // upstream
    input  wire logic [DATA_WIDTH-1:0] data_i,
    input  wire logic                  rdy_i,
    output      logic                  ack_o,
    // downstream
    output      logic [DATA_WIDTH-1:0] data_o,
    output      logic                  rdy_o,
    input  wire logic                  ack_i
);

    fifo_rbuf_state_e      state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  rdy_q;
    logic                  ack_q;

    // Handshakes are qualified by the registered outputs only, so no input
    // can propagate to an output within a cycle.
    logic up_xfer;
    logic dn_xfer;

    assign up_xfer = rdy_i & ack_q;
    assign dn_xfer = rdy_q & ack_i;

    // Single FSM: state, storage and registered handshake outputs together.
    // ack_q mirrors (next state != FULL), rdy_q mirrors (next state != EMPTY).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            rdy_q   <= 1'b0;
            ack_q   <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_xfer) begin
                        state_q <= BUSY;
                        data_q  <= data_i;
                        rdy_q   <= 1'b1;
                        ack_q   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (up_xfer && !dn_xfer) begin
                        // consumer stalled: park the new word, stop accepting
                        state_q <= FULL;
                        skid_q  <= data_i;
                        ack_q   <= 1'b0;
                    end else if (!up_xfer && dn_xfer) begin
                        // data_o keeps its stale value; rdy_o marks it invalid
                        state_q <= EMPTY;
                        rdy_q   <= 1'b0;
                    end else if (up_xfer && dn_xfer) begin
                        data_q  <= data_i;
                    end
                end
                FULL: begin
                    // rdy_i is irrelevant here since ack_o is low
                    if (dn_xfer) begin
                        state_q <= BUSY;
                        data_q  <= skid_q;
                        ack_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b0;
                    ack_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ack_o  = ack_q;
    assign rdy_o  = rdy_q;
    assign data_o = data_q;

endmodule : fifo_rbuf
`default_nettype wire

// File: tb/tb_fifo_rbuf.sv
`default_nettype none
// ============================================================================
//  Module    : tb_fifo_rbuf
//  Purpose   : Self-checking bench for fifo_rbuf: directed vector table,
//              continuous streaming, randomised handshakes against a
//              queue scoreboard, and input-toggle probes on the outputs.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_fifo_rbuf;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_rbuf_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rbuf #(
        .DATA_WIDTH (DW),
        .RST_VAL    (32'h0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .data_i (bus.data_up),
        .rdy_i  (bus.rdy_up),
        .ack_o  (bus.ack_up),
        .data_o (bus.data_dn),
        .rdy_o  (bus.rdy_dn),
        .ack_i  (bus.ack_dn)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: a two-deep reference FIFO. Occupancy alone predicts
    // rdy_o/ack_o; its head predicts data_o.
    // ------------------------------------------------------------------
    logic [31:0] sb[$];
    bit          mon_en    = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_data;
    int          n_pop     = 0;
    bit          m_up, m_dn;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                sb.delete();
                hold_prev = 1'b0;
            end else begin
                chk("rdy_o", {31'b0, bus.rdy_dn}, {31'b0, (sb.size() > 0)});
                chk("ack_o", {31'b0, bus.ack_up}, {31'b0, (sb.size() < 2)});
                if (hold_prev) chk("stable_data_o", bus.data_dn, prev_data);
                if (sb.size() > 0) chk("data_o_order", bus.data_dn, sb[0]);
                m_up = bus.rdy_up && (sb.size() < 2);
                m_dn = (sb.size() > 0) && bus.ack_dn;
                hold_prev = (sb.size() > 0) && !bus.ack_dn;
                prev_data = bus.data_dn;
                if (m_dn) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
                if (m_up) sb.push_back(bus.data_up);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed vectors: inputs for one edge, outputs expected after it
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] din;
        logic        ack;
        logic        e_rdy;
        logic        e_ack;
        logic [31:0] e_data;
        logic        chk_data;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mkv(input logic r, input logic rd, input logic [31:0] d,
                                 input logic a, input logic er, input logic ea,
                                 input logic [31:0] ed, input logic cd);
        vec_t v;
        v.rst = r; v.rdy = rd; v.din = d; v.ack = a;
        v.e_rdy = er; v.e_ack = ea; v.e_data = ed; v.chk_data = cd;
        return v;
    endfunction

    task automatic drive(input logic r, input logic rd, input logic [31:0] d, input logic a);
        rst         = r;
        bus.rdy_up  = rd;
        bus.data_up = d;
        bus.ack_dn  = a;
    endtask

    // Flip both inputs mid-cycle; registered outputs must not move.
    task automatic probe_comb();
        logic        s_rdy, s_ack;
        logic [31:0] s_data;
        #1;
        s_rdy = bus.rdy_dn; s_ack = bus.ack_up; s_data = bus.data_dn;
        bus.rdy_up = ~bus.rdy_up;
        bus.ack_dn = ~bus.ack_dn;
        #1;
        chk("comb_rdy_o", {31'b0, bus.rdy_dn}, {31'b0, s_rdy});
        chk("comb_ack_o", {31'b0, bus.ack_up}, {31'b0, s_ack});
        chk("comb_data_o", bus.data_dn, s_data);
        bus.rdy_up = ~bus.rdy_up;
        bus.ack_dn = ~bus.ack_dn;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        // reset, then one word with consumer ready
        vecs[0]  = mkv(1, 0, 32'h0,        0, 0, 1, 32'h0,        1);
        vecs[1]  = mkv(0, 1, 32'hA5A5A5A5, 1, 1, 1, 32'hA5A5A5A5, 1);
        vecs[2]  = mkv(0, 0, 32'h0,        1, 0, 1, 32'h0,        0);
        // stream 1..; consumer stalls from the second word
        vecs[3]  = mkv(0, 1, 32'h1,        0, 1, 1, 32'h1,        1);
        vecs[4]  = mkv(0, 1, 32'h2,        0, 1, 0, 32'h1,        1);
        vecs[5]  = mkv(0, 1, 32'h3,        0, 1, 0, 32'h1,        1);
        vecs[6]  = mkv(0, 1, 32'h4,        0, 1, 0, 32'h1,        1);
        vecs[7]  = mkv(0, 1, 32'h5,        1, 1, 1, 32'h2,        1);
        vecs[8]  = mkv(0, 0, 32'h6,        1, 0, 1, 32'h0,        0);
        // fill with 0x11/0x22, then reset while full
        vecs[9]  = mkv(0, 1, 32'h11,       0, 1, 1, 32'h11,       1);
        vecs[10] = mkv(0, 1, 32'h22,       0, 1, 0, 32'h11,       1);
        vecs[11] = mkv(1, 1, 32'h33,       1, 0, 1, 32'h0,        1);
        vecs[12] = mkv(0, 0, 32'h0,        1, 0, 1, 32'h0,        1);
        vecs[13] = mkv(0, 0, 32'h0,        1, 0, 1, 32'h0,        1);

        drive(1'b1, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].din, vecs[i].ack);
            @(posedge clk);
            #1;
            if (i == 0) mon_en = 1'b1;
            chk($sformatf("vec%0d_rdy_o", i), {31'b0, bus.rdy_dn}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_ack_o", i), {31'b0, bus.ack_up}, {31'b0, vecs[i].e_ack});
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data_o", i), bus.data_dn, vecs[i].e_data);
        end

        // continuous stream: one word per cycle, never FULL
        base = n_pop;
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b1, 32'h1000 + i, 1'b1);
            @(posedge clk);
            #1;
            chk("stream_ack_o", {31'b0, bus.ack_up}, 32'h1);
            chk("stream_rdy_o", {31'b0, bus.rdy_dn}, 32'h1);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("stream_count", n_pop - base, 32'd100);

        // random handshakes
        for (int i = 0; i < 10000; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (i % 500 == 0) probe_comb();
            @(posedge clk);
            #1;
        end

        // drain
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 32'd0);
        chk("drain_rdy_o", {31'b0, bus.rdy_dn}, 32'h0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fifo_rbuf
`default_nettype wire
